// File: rtl/mem_access_stage.sv
// MIPS MEM stage: byte/half/word loads and stores to a private data memory, plus branch/JR redirect.
// Latency: MEM_LATENCY cycles per access; load data is combinational in the final cycle.
// Backpressure: Stall_out is high for the first MEM_LATENCY-1 cycles and upstream holds its inputs.
//
// Ports: Clk/Rst (sync, active-high); MemRead_in/MemWrite_in/MuxLoad_in/ALUResult_in/Rt_in describe the access;
// Branch_in/Zero_in/JRegControl_in/PC2ndAdder_in/Rs_in drive the redirect;
// ReadData_out/Stall_out/Misaligned_out/PCSrc_out/PCTarget_out are the outputs.
module mem_access_stage #(
    parameter int DEPTH_WORDS = 1024,
    parameter int MEM_LATENCY = 2
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        MemRead_in,
    input  logic        MemWrite_in,
    input  logic [1:0]  MuxLoad_in,
    input  logic [31:0] ALUResult_in,
    input  logic [31:0] Rt_in,
    input  logic        Branch_in,
    input  logic        Zero_in,
    input  logic        JRegControl_in,
    input  logic [31:0] PC2ndAdder_in,
    input  logic [31:0] Rs_in,
    output logic [31:0] ReadData_out,
    output logic        Stall_out,
    output logic        Misaligned_out,
    output logic        PCSrc_out,
    output logic [31:0] PCTarget_out
);

    localparam int IW = $clog2(DEPTH_WORDS);
    // A single-cycle configuration still needs a 1-bit counter so the declaration stays legal.
    localparam int CW = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
    localparam logic MULTI = (MEM_LATENCY > 1);

    typedef enum logic {IDLE, WAIT} state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [31:0]     mem [DEPTH_WORDS];

    logic [IW-1:0]   idx;
    logic            req;
    logic            aligned;
    logic            go;
    logic            is_load;
    logic            final_cyc;
    logic            commit;
    logic [3:0]      be;
    logic [31:0]     wdata;
    logic [31:0]     rword;
    logic [7:0]      lane_b;
    logic [15:0]     lane_h;
    logic [31:0]     ld_data;
    logic            unused_addr;

    // Upper address bits alias onto the same words.
    assign idx         = ALUResult_in[IW+1:2];
    assign unused_addr = ^ALUResult_in[31:IW+2];

    assign req     = MemRead_in | MemWrite_in;
    assign go      = req & aligned;
    // Read and write together is treated as a store.
    assign is_load = MemRead_in & ~MemWrite_in;

    // Final (non-stalled) cycle of an access: immediately in IDLE when single-cycle, otherwise when WAIT drains.
    assign final_cyc = ~Rst & go &
                       (((state == IDLE) & ~MULTI) | ((state == WAIT) & (cnt == '0)));
    assign commit    = final_cyc & MemWrite_in;

    assign Stall_out = ~Rst & ((state == IDLE) ? (go & MULTI) : (cnt != '0));

    always_comb begin
        aligned = 1'b1;
        be      = 4'b0000;
        wdata   = Rt_in;
        case (MuxLoad_in)
            2'b00: begin
                aligned = (ALUResult_in[1:0] == 2'b00);
                be      = 4'b1111;
            end
            2'b01: begin
                aligned = ~ALUResult_in[0];
                be      = ALUResult_in[1] ? 4'b1100 : 4'b0011;
                wdata   = {2{Rt_in[15:0]}};
            end
            default: begin
                be      = 4'b0001 << ALUResult_in[1:0];
                wdata   = {4{Rt_in[7:0]}};
            end
        endcase
    end

    assign rword  = mem[idx];
    assign lane_b = rword[{ALUResult_in[1:0], 3'b000} +: 8];
    assign lane_h = ALUResult_in[1] ? rword[31:16] : rword[15:0];

    always_comb begin
        ld_data = rword;
        case (MuxLoad_in)
            2'b00:   ld_data = rword;
            2'b01:   ld_data = {{16{lane_h[15]}}, lane_h};
            2'b10:   ld_data = {{24{lane_b[7]}}, lane_b};
            default: ld_data = {24'h0, lane_b};
        endcase
    end

    assign ReadData_out   = (final_cyc & is_load) ? ld_data : 32'h0;
    assign Misaligned_out = ~Rst & req & ~aligned;

    assign PCSrc_out    = ~Rst & ((Branch_in & Zero_in) | JRegControl_in) & ~Stall_out;
    assign PCTarget_out = JRegControl_in ? Rs_in : PC2ndAdder_in;

    // Memory array is deliberately not reset.
    always_ff @(posedge Clk) begin
        if (commit) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) begin
                    mem[idx][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (go && MULTI) begin
                        state <= WAIT;
                        cnt   <= CW'(MULTI ? MEM_LATENCY - 2 : 0);
                    end
                end
                WAIT: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
module tb_mem_access_stage;

    logic        Clk = 1'b0;
    logic        rst      [3];
    logic        rd       [3];
    logic        wr       [3];
    logic [1:0]  mux      [3];
    logic [31:0] addr     [3];
    logic [31:0] wdat     [3];
    logic        br       [3];
    logic        zero     [3];
    logic        jr       [3];
    logic [31:0] tgt      [3];
    logic [31:0] rs       [3];
    logic [31:0] rdata    [3];
    logic        stall    [3];
    logic        misal    [3];
    logic        pcsrc    [3];
    logic [31:0] pctgt    [3];

    int n_chk = 0;
    int n_bad = 0;

    always #5 Clk = ~Clk;

    // Instance 0: latency 2, instance 1: latency 3, instance 2: single-cycle.
    mem_access_stage #(.DEPTH_WORDS(1024), .MEM_LATENCY(2)) u_lat2 (
        .Clk(Clk), .Rst(rst[0]), .MemRead_in(rd[0]), .MemWrite_in(wr[0]), .MuxLoad_in(mux[0]),
        .ALUResult_in(addr[0]), .Rt_in(wdat[0]), .Branch_in(br[0]), .Zero_in(zero[0]),
        .JRegControl_in(jr[0]), .PC2ndAdder_in(tgt[0]), .Rs_in(rs[0]), .ReadData_out(rdata[0]),
        .Stall_out(stall[0]), .Misaligned_out(misal[0]), .PCSrc_out(pcsrc[0]), .PCTarget_out(pctgt[0]));

    mem_access_stage #(.DEPTH_WORDS(1024), .MEM_LATENCY(3)) u_lat3 (
        .Clk(Clk), .Rst(rst[1]), .MemRead_in(rd[1]), .MemWrite_in(wr[1]), .MuxLoad_in(mux[1]),
        .ALUResult_in(addr[1]), .Rt_in(wdat[1]), .Branch_in(br[1]), .Zero_in(zero[1]),
        .JRegControl_in(jr[1]), .PC2ndAdder_in(tgt[1]), .Rs_in(rs[1]), .ReadData_out(rdata[1]),
        .Stall_out(stall[1]), .Misaligned_out(misal[1]), .PCSrc_out(pcsrc[1]), .PCTarget_out(pctgt[1]));

    mem_access_stage #(.DEPTH_WORDS(1024), .MEM_LATENCY(1)) u_lat1 (
        .Clk(Clk), .Rst(rst[2]), .MemRead_in(rd[2]), .MemWrite_in(wr[2]), .MuxLoad_in(mux[2]),
        .ALUResult_in(addr[2]), .Rt_in(wdat[2]), .Branch_in(br[2]), .Zero_in(zero[2]),
        .JRegControl_in(jr[2]), .PC2ndAdder_in(tgt[2]), .Rs_in(rs[2]), .ReadData_out(rdata[2]),
        .Stall_out(stall[2]), .Misaligned_out(misal[2]), .PCSrc_out(pcsrc[2]), .PCTarget_out(pctgt[2]));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // Present one access at #1 after a rising edge, count stalled cycles, capture outputs
    // in the final cycle, then let the final edge pass and drop the request.
    task automatic access(input int k, input logic r, input logic w, input logic [1:0] m,
                          input logic [31:0] a, input logic [31:0] wd,
                          output logic [31:0] data, output int stalls, output logic mis);
        bit done;
        rd[k] = r; wr[k] = w; mux[k] = m; addr[k] = a; wdat[k] = wd;
        stalls = 0; data = 32'h0; mis = 1'b0; done = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge Clk);
            if (stall[k]) begin
                stalls++;
            end else begin
                data = rdata[k];
                mis  = misal[k];
                done = 1'b1;
                break;
            end
            @(posedge Clk); #1;
        end
        if (!done) check("access_timeout", 32'(stalls), 32'd0);
        @(posedge Clk); #1;
        rd[k] = 1'b0; wr[k] = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        int          s;
        logic        mis;

        for (int k = 0; k < 3; k++) begin
            rst[k] = 1'b1; rd[k] = 1'b0; wr[k] = 1'b0; mux[k] = 2'b00; addr[k] = 32'h0;
            wdat[k] = 32'h0; br[k] = 1'b0; zero[k] = 1'b0; jr[k] = 1'b0; tgt[k] = 32'h0; rs[k] = 32'h0;
        end
        // Drive an aligned load and a taken branch during reset: outputs must stay quiet.
        rd[0] = 1'b1; addr[0] = 32'h10; br[0] = 1'b1; zero[0] = 1'b1; tgt[0] = 32'h44;
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        check("rst_stall", 32'(stall[0]), 32'd0);
        check("rst_pcsrc", 32'(pcsrc[0]), 32'd0);
        check("rst_rdata", rdata[0], 32'h0);
        check("rst_pctgt", pctgt[0], 32'h44);
        @(posedge Clk); #1;
        for (int k = 0; k < 3; k++) rst[k] = 1'b0;
        rd[0] = 1'b0; br[0] = 1'b0; zero[0] = 1'b0;

        // ---- latency 2: store then loads of every size ----
        access(0, 1'b0, 1'b1, 2'b00, 32'h10, 32'hDEADBEEF, d, s, mis);
        check("st_word_stalls", 32'(s), 32'd1);
        access(0, 1'b1, 1'b0, 2'b00, 32'h10, 32'h0, d, s, mis);
        check("ld_word_stalls", 32'(s), 32'd1);
        check("ld_word", d, 32'hDEADBEEF);
        access(0, 1'b1, 1'b0, 2'b10, 32'h13, 32'h0, d, s, mis);
        check("ld_byte_sx", d, 32'hFFFFFFDE);
        access(0, 1'b1, 1'b0, 2'b11, 32'h13, 32'h0, d, s, mis);
        check("ld_byte_zx", d, 32'h000000DE);
        access(0, 1'b1, 1'b0, 2'b01, 32'h12, 32'h0, d, s, mis);
        check("ld_half_hi", d, 32'hFFFFDEAD);
        access(0, 1'b1, 1'b0, 2'b01, 32'h10, 32'h0, d, s, mis);
        check("ld_half_lo", d, 32'hFFFFBEEF);
        access(0, 1'b0, 1'b1, 2'b10, 32'h11, 32'hAAAAAA55, d, s, mis);
        access(0, 1'b1, 1'b0, 2'b00, 32'h10, 32'h0, d, s, mis);
        check("ld_after_stb", d, 32'hDEAD55EF);

        // Misaligned word load: flagged, no stall, zero data.
        access(0, 1'b1, 1'b0, 2'b00, 32'h12, 32'h0, d, s, mis);
        check("mis_ld_flag", 32'(mis), 32'd1);
        check("mis_ld_stall", 32'(s), 32'd0);
        check("mis_ld_data", d, 32'h0);
        // Misaligned half store must not touch memory.
        access(0, 1'b0, 1'b1, 2'b01, 32'h11, 32'h0000FFFF, d, s, mis);
        check("mis_st_flag", 32'(mis), 32'd1);
        access(0, 1'b1, 1'b0, 2'b00, 32'h10, 32'h0, d, s, mis);
        check("mis_st_nowrite", d, 32'hDEAD55EF);

        // Half store to upper lanes, then read and write together counts as a store.
        access(0, 1'b0, 1'b1, 2'b01, 32'h12, 32'h00001234, d, s, mis);
        access(0, 1'b1, 1'b0, 2'b00, 32'h10, 32'h0, d, s, mis);
        check("ld_after_sth", d, 32'h123455EF);
        access(0, 1'b1, 1'b1, 2'b00, 32'h14, 32'h11223344, d, s, mis);
        check("rdwr_data_zero", d, 32'h0);
        access(0, 1'b1, 1'b0, 2'b00, 32'h14, 32'h0, d, s, mis);
        check("rdwr_stored", d, 32'h11223344);

        // ---- redirect ----
        br[0] = 1'b1; zero[0] = 1'b1; tgt[0] = 32'h40; rs[0] = 32'h100;
        @(negedge Clk);
        check("br_pcsrc", 32'(pcsrc[0]), 32'd1);
        check("br_tgt", pctgt[0], 32'h40);
        jr[0] = 1'b1;
        @(negedge Clk);
        check("jr_tgt", pctgt[0], 32'h100);
        check("jr_pcsrc", 32'(pcsrc[0]), 32'd1);
        zero[0] = 1'b0; jr[0] = 1'b0;
        @(negedge Clk);
        check("nt_pcsrc", 32'(pcsrc[0]), 32'd0);
        @(posedge Clk); #1;
        zero[0] = 1'b1; rd[0] = 1'b1; mux[0] = 2'b00; addr[0] = 32'h10;
        @(negedge Clk);
        check("stall_mask_stall", 32'(stall[0]), 32'd1);
        check("stall_mask_pcsrc", 32'(pcsrc[0]), 32'd0);
        @(posedge Clk); #1;
        @(negedge Clk);
        check("post_stall_pcsrc", 32'(pcsrc[0]), 32'd1);
        @(posedge Clk); #1;
        rd[0] = 1'b0; br[0] = 1'b0; zero[0] = 1'b0;

        // ---- latency 3: reset aborts a pending store ----
        access(1, 1'b0, 1'b1, 2'b00, 32'h20, 32'hA5A5A5A5, d, s, mis);
        check("l3_st_stalls", 32'(s), 32'd2);
        wr[1] = 1'b1; mux[1] = 2'b00; addr[1] = 32'h20; wdat[1] = 32'h12345678;
        @(negedge Clk);
        check("l3_abort_c1_stall", 32'(stall[1]), 32'd1);
        @(posedge Clk); #1;
        rst[1] = 1'b1;
        @(negedge Clk);
        check("l3_abort_rst_stall", 32'(stall[1]), 32'd0);
        @(posedge Clk); #1;
        rst[1] = 1'b0; wr[1] = 1'b0;
        @(negedge Clk);
        check("l3_after_rst_stall", 32'(stall[1]), 32'd0);
        @(posedge Clk); #1;
        access(1, 1'b1, 1'b0, 2'b00, 32'h20, 32'h0, d, s, mis);
        check("l3_ld_stalls", 32'(s), 32'd2);
        check("l3_ld_prior", d, 32'hA5A5A5A5);

        // ---- latency 1: address wrap, no stall ----
        access(2, 1'b0, 1'b1, 2'b00, 32'h1000, 32'hCAFEF00D, d, s, mis);
        check("l1_st_stalls", 32'(s), 32'd0);
        access(2, 1'b1, 1'b0, 2'b00, 32'h0, 32'h0, d, s, mis);
        check("l1_ld_stalls", 32'(s), 32'd0);
        check("l1_ld_wrap", d, 32'hCAFEF00D);
        access(2, 1'b1, 1'b0, 2'b11, 32'h1, 32'h0, d, s, mis);
        check("l1_ld_byte_zx", d, 32'h000000F0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_access_stage.md
# mem_access_stage

Memory-access (MEM) stage of the 5-stage MIPS pipeline, fed directly by the EX/MEM pipeline register outputs and feeding the MEM/WB register and the IF-stage PC mux. It performs byte/half/word loads and stores against a private data memory with a configurable access latency, and asserts a stall while an access is in flight. It also resolves the branch and jump-register redirect.

## Interface
- DEPTH_WORDS, 1024, data memory depth in 32-bit words (power of two)
- MEM_LATENCY, 2, cycles per memory access (>=1); 1 = single-cycle, no stall
- Clk  in  1  clock; all state updates on posedge
- Rst  in  1  reset; synchronous, active-high
- MemRead_in  in  1  load request
- MemWrite_in  in  1  store request
- MuxLoad_in  in  2  access size: 00 word, 01 half sign-ext, 10 byte sign-ext, 11 byte zero-ext
- ALUResult_in  in  32  byte address
- Rt_in  in  32  store data
- Branch_in  in  1  conditional branch
- Zero_in  in  1  ALU zero flag
- JRegControl_in  in  1  jump-register
- PC2ndAdder_in  in  32  branch target
- Rs_in  in  32  jump-register target
- ReadData_out  out  32  formatted load data
- Stall_out  out  1  freeze PC, IF/ID, ID/EX, EX/MEM
- Misaligned_out  out  1  access dropped: misaligned
- PCSrc_out  out  1  take redirect
- PCTarget_out  out  32  redirect target

## Operation
- Memory: byte-enabled, little-endian, word index = ALUResult_in[log2(DEPTH_WORDS)+1:2]; higher address bits ignored (aliasing/wrap). Contents not cleared by reset.
- Alignment: word needs addr[1:0]=00, half needs addr[0]=0, byte always aligned. Misaligned request: Misaligned_out=1 (combinational), no write, ReadData_out=0, no stall.
- Loads: word = mem word; half = addr[1]?[31:16]:[15:0], sign-extended; byte = lane addr[1:0], sign- or zero-extended per MuxLoad_in.
- Stores: word writes all 4 lanes from Rt_in; half writes lanes {addr[1],0},{addr[1],1} from Rt_in[15:0]; byte (10 or 11) writes lane addr[1:0] from Rt_in[7:0].
- MemRead_in and MemWrite_in both high: treated as store; ReadData_out=0.
- No request: ReadData_out=0.
- FSM states IDLE, WAIT; down-counter cnt (width clog2(MEM_LATENCY)).
  - IDLE, aligned request, MEM_LATENCY=1: Stall_out=0, store commits this edge, stay IDLE.
  - IDLE, aligned request, MEM_LATENCY>1: Stall_out=1, next WAIT, cnt<=MEM_LATENCY-2.
  - WAIT, cnt!=0: Stall_out=1, cnt<=cnt-1.
  - WAIT, cnt==0: Stall_out=0, ReadData_out valid, store commits this edge, next IDLE.
- Inputs are held stable by upstream while Stall_out=1; block does not latch them.
- Redirect: PCSrc_out = ((Branch_in & Zero_in) | JRegControl_in) & ~Stall_out; PCTarget_out = JRegControl_in ? Rs_in : PC2ndAdder_in (JRegControl wins).

## Timing
- Access occupies exactly MEM_LATENCY cycles; Stall_out high for the first MEM_LATENCY-1 of them.
- Load data valid combinationally in the final (non-stalled) cycle, captured by MEM/WB on that edge.
- Store visible to a load issued the following cycle.
- Back-to-back accesses: each new request starts a fresh sequence from IDLE; no bubble inserted by this block.
- Rst high: state<=IDLE, cnt<=0, no write that edge; while Rst high Stall_out=0, PCSrc_out=0, Misaligned_out=0, ReadData_out=0, PCTarget_out follows the combinational mux.
- Rst mid-WAIT: access aborted, pending store never committed.

## Test plan
- MEM_LATENCY=2: store word 0xDEADBEEF @0x10 -> Stall_out=1 one cycle, then 0; load word @0x10 -> ReadData_out=0xDEADBEEF in its second cycle.
- After that store: load byte @0x13 (10) -> 0xFFFFFFDE; (11) -> 0x000000DE; half @0x12 (01) -> 0xFFFFDEAD; store byte 0x55 @0x11 then word load -> 0xDEAD55EF.
- Load word @0x12 -> Misaligned_out=1, Stall_out=0, ReadData_out=0; misaligned half store @0x11 -> memory unchanged.
- Branch_in=1, Zero_in=1, PC2ndAdder_in=0x40 -> PCSrc_out=1, PCTarget_out=0x40; add JRegControl_in=1, Rs_in=0x100 -> PCTarget_out=0x100; Zero_in=0, JRegControl_in=0 -> PCSrc_out=0; redirect masked while Stall_out=1.
- MEM_LATENCY=3, store 0x12345678 @0x20, assert Rst in second cycle -> Stall_out=0 next cycle, later load @0x20 returns prior contents.
- DEPTH_WORDS=1024: store 0xCAFEF00D @0x1000, load @0x0 -> 0xCAFEF00D; MEM_LATENCY=1 load -> Stall_out never asserted.
